sat_accumulator: RTL and testbench

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

---
 rtl/sat_accumulator.sv | 165 ++++++++++++++++
 tb/tb_sat_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_accumulator.sv
// ---------------------------------------------------------------------------
// sat_accumulator
//
// Running accumulator with optional saturation and overflow flags. Every
// cycle with in_valid=1 adds in_data to the accumulator; on overflow the
// result is either clamped to the violated bound (SATURATE=1) or wrapped
// modulo 2^W (SATURATE=0). Overflow is reported either way.
//
// Parameters
//   W        data / accumulator width (2..32)
//   SIGNED   1 = two's-complement operands, 0 = unsigned
//   SATURATE 1 = clamp on overflow, 0 = wrap
//   CNT_W    width of the accepted-sample counter
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   in_valid   in_data holds a sample to accumulate this cycle
//   in_data    sample, interpreted per SIGNED
//   clear      synchronous restart; with in_valid the sample is added to 0
//   out_valid  accumulator was updated by a sample on the previous edge
//   out_data   accumulator value
//   sat_pulse  the sample accepted on the previous edge overflowed
//   sat_sticky some overflow occurred since the last clear/reset
//   count      samples accepted since the last clear/reset (saturating)
//
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module sat_accumulator #(
  parameter int W        = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             clear,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             sat_pulse,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] count
);

  // Operating state: IDLE means nothing accumulated since clear/reset.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_reg,  state_next;
  logic [W-1:0]     acc_reg,    acc_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             valid_reg,  valid_next;
  logic             pulse_reg,  pulse_next;
  logic             sticky_reg, sticky_next;

  // Datapath: the addend base is forced to zero on clear so that a
  // clear+sample cycle starts a fresh accumulation with that sample.
  logic [W-1:0] base;
  logic [W:0]   base_ext;
  logic [W:0]   in_ext;
  logic [W:0]   sum;
  logic         overflow;
  logic [W-1:0] bound;
  logic [W-1:0] result;
  logic [CNT_W-1:0] count_inc;

  assign base = clear ? '0 : acc_reg;

  generate
    if (SIGNED != 0) begin : g_signed
      assign base_ext = {base[W-1], base};
      assign in_ext   = {in_data[W-1], in_data};
      // With one guard bit, the two top bits disagree exactly when the
      // true sum is outside [-2^(W-1), 2^(W-1)-1].
      assign overflow = sum[W] ^ sum[W-1];
      // Guard bit carries the true sign: negative overflow clamps to min.
      assign bound    = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin : g_unsigned
      assign base_ext = {1'b0, base};
      assign in_ext   = {1'b0, in_data};
      // Only a carry out of the top bit can overflow; no underflow exists.
      assign overflow = sum[W];
      assign bound    = {W{1'b1}};
    end
  endgenerate

  assign sum = base_ext + in_ext;

  generate
    if (SATURATE != 0) begin : g_clamp
      assign result = overflow ? bound : sum[W-1:0];
    end else begin : g_wrap
      assign result = sum[W-1:0];
    end
  endgenerate

  // First sample after IDLE always yields 1; afterwards saturate at max.
  always_comb begin
    count_inc = count_reg;
    if (state_reg == ST_IDLE) begin
      count_inc = CNT_ONE;
    end else if (count_reg != CNT_MAX) begin
      count_inc = count_reg + CNT_ONE;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;
    sticky_next = sticky_reg;
    valid_next  = 1'b0;
    pulse_next  = 1'b0;

    if (in_valid) begin
      acc_next   = result;
      valid_next = 1'b1;
      pulse_next = overflow;
      state_next = ST_ACCUM;
      if (clear) begin
        // Base is zero here, so overflow is necessarily 0.
        count_next  = CNT_ONE;
        sticky_next = overflow;
      end else begin
        count_next  = count_inc;
        sticky_next = sticky_reg | overflow;
      end
    end else if (clear) begin
      acc_next    = '0;
      count_next  = '0;
      sticky_next = 1'b0;
      state_next  = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      acc_reg    <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      pulse_reg  <= pulse_next;
      sticky_reg <= sticky_next;
    end
  end

  assign out_valid  = valid_reg;
  assign out_data   = acc_reg;
  assign sat_pulse  = pulse_reg;
  assign sat_sticky = sticky_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_sat_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sat_accumulator
//
// Four accumulators share one stimulus stream:
//   0: SIGNED=1 SATURATE=1 CNT_W=8
//   1: SIGNED=1 SATURATE=0 CNT_W=8
//   2: SIGNED=0 SATURATE=1 CNT_W=8
//   3: SIGNED=1 SATURATE=1 CNT_W=2
// The driver updates an integer-arithmetic reference model per instance and
// queues the expected outputs; a monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_sat_accumulator;

  typedef struct {
    int acc;
    int cnt;
    bit sticky;
    bit valid;
    bit pulse;
  } ms_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic clear = 1'b0;

  logic [3:0] od [4];
  logic       ov [4];
  logic       sp [4];
  logic       ss [4];
  logic [7:0] cnt8 [3];
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  bit cfg_sgn [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit cfg_sat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cfg_cw  [4] = '{8, 8, 8, 2};

  ms_t model [4];
  ms_t exp_q [$];

  always #5 clk = ~clk;

  sat_accumulator #(.W(4), .SIGNED(1), .SATURATE(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(ov[0]), .out_data(od[0]), .sat_pulse(sp[0]), .sat_sticky(ss[0]), .count(cnt8[0]));
  sat_accumulator #(.W(4), .SIGNED(1), .SATURATE(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(ov[1]), .out_data(od[1]), .sat_pulse(sp[1]), .sat_sticky(ss[1]), .count(cnt8[1]));
  sat_accumulator #(.W(4), .SIGNED(0), .SATURATE(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(ov[2]), .out_data(od[2]), .sat_pulse(sp[2]), .sat_sticky(ss[2]), .count(cnt8[2]));
  sat_accumulator #(.W(4), .SIGNED(1), .SATURATE(1), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_valid(ov[3]), .out_data(od[3]), .sat_pulse(sp[3]), .sat_sticky(ss[3]), .count(cnt2));

  // Reference: accumulate as a plain integer, then apply the range rules.
  function automatic ms_t model_step(ms_t s, bit sgn, bit sat, int cw,
                                     bit r, bit v, logic [3:0] d, bit c);
    ms_t n;
    int x, base, total, hi, lo, cmax, w;
    n = s;
    hi = sgn ? 7 : 15;
    lo = sgn ? -8 : 0;
    cmax = (1 << cw) - 1;
    x = sgn ? int'($signed(d)) : int'(d);
    n.valid = 1'b0;
    n.pulse = 1'b0;
    if (r) begin
      n.acc = 0; n.cnt = 0; n.sticky = 1'b0;
    end else if (v) begin
      base = c ? 0 : s.acc;
      total = base + x;
      if (total > hi || total < lo) begin
        n.pulse = 1'b1;
        if (sat) begin
          n.acc = (total > hi) ? hi : lo;
        end else begin
          w = total & 15;
          if (sgn && w > 7) w = w - 16;
          n.acc = w;
        end
      end else begin
        n.acc = total;
      end
      n.valid = 1'b1;
      n.cnt = c ? 1 : ((s.cnt < cmax) ? s.cnt + 1 : cmax);
      n.sticky = c ? n.pulse : (s.sticky | n.pulse);
    end else if (c) begin
      n.acc = 0; n.cnt = 0; n.sticky = 1'b0;
    end
    return n;
  endfunction

  task automatic step(input bit r, input bit v, input logic [3:0] d, input bit c);
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_data = d;
    clear = c;
    for (int i = 0; i < 4; i++) begin
      model[i] = model_step(model[i], cfg_sgn[i], cfg_sat[i], cfg_cw[i], r, v, d, c);
      exp_q.push_back(model[i]);
    end
    $display("drive rst=%0b v=%0b d=%0h clr=%0b -> exp0 data=%0d cnt=%0d sticky=%0b",
             r, v, d, c, model[0].acc, model[0].cnt, model[0].sticky);
  endtask

  task automatic cmp(input int i, input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL dut%0d %s got=%0h exp=%0h", i, name, got, want);
    end
  endtask

  // Monitor: one comparison set per instance after every edge driven by step().
  initial begin
    ms_t e;
    logic [7:0] c_act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= 4) begin
        for (int i = 0; i < 4; i++) begin
          e = exp_q.pop_front();
          c_act = (i == 3) ? {6'b0, cnt2} : cnt8[i];
          cmp(i, "out_data",   {4'b0, od[i]}, 8'(e.acc & 15));
          cmp(i, "out_valid",  {7'b0, ov[i]}, {7'b0, e.valid});
          cmp(i, "sat_pulse",  {7'b0, sp[i]}, {7'b0, e.pulse});
          cmp(i, "sat_sticky", {7'b0, ss[i]}, {7'b0, e.sticky});
          cmp(i, "count",      c_act,         8'(e.cnt));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) model[i] = '{0, 0, 1'b0, 1'b0, 1'b0};
    // Samples 3,2,1
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h3, 0);
    step(0, 1, 4'h2, 0);
    step(0, 1, 4'h1, 0);
    // 4,4 overflow then -1
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h4, 0);
    step(0, 1, 4'h4, 0);
    step(0, 1, 4'hF, 0);
    // -4,-7 negative overflow, then clear with sample 2
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'hC, 0);
    step(0, 1, 4'h9, 0);
    step(0, 1, 4'h2, 1);
    // 7,1 and 9,9
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h7, 0);
    step(0, 1, 4'h1, 0);
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h9, 0);
    step(0, 1, 4'h9, 0);
    // Accumulate to 5, idle 3 cycles, reset with a sample present
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h5, 0);
    step(0, 0, 4'h3, 0);
    step(0, 0, 4'h3, 0);
    step(0, 0, 4'h3, 0);
    step(1, 1, 4'h6, 1);
    step(0, 0, 4'h0, 0);
    // Five zero samples: 2-bit count sticks at 3
    for (int k = 0; k < 5; k++) step(0, 1, 4'h0, 0);
    // Clear without a sample, then clear on an idle IDLE state
    step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 1);
    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end
    step(0, 0, 4'h0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain queue_left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
